// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: load-type encodings, inter-stage bus widths and
// bus field offsets used by the MEM stage and its load aligner.
package cpu_defs;

  // Inter-stage bus widths
  localparam int EX_TO_MEM_W = 106;
  localparam int MEM_TO_WB_W = 102;
  localparam int MEM_TO_ID_W = 39;

  // Load-type encodings carried in the EX_to_MEM bus
  localparam logic [2:0] LD_W  = 3'b000;
  localparam logic [2:0] LD_B  = 3'b001;
  localparam logic [2:0] LD_H  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;

  // EX_to_MEM bus field offsets
  localparam int EXB_RES_FROM_MEM = 105;
  localparam int EXB_LD_TYPE_LSB  = 102;
  localparam int EXB_ALU_LSB      = 70;
  localparam int EXB_GR_WE        = 69;
  localparam int EXB_DEST_LSB     = 64;
  localparam int EXB_PC_LSB       = 32;
  localparam int EXB_INST_LSB     = 0;

  // MEM_to_WB bus field offsets
  localparam int WBB_RESULT_LSB = 70;
  localparam int WBB_GR_WE      = 69;
  localparam int WBB_DEST_LSB   = 64;

  // MEM_to_ID bus field offsets
  localparam int IDB_FWD_WE    = 38;
  localparam int IDB_IS_LOAD   = 37;
  localparam int IDB_DEST_LSB  = 32;

  // Halfword loads (signed or unsigned)
  function automatic logic ld_is_half(input logic [2:0] t);
    return (t == LD_H) || (t == LD_HU);
  endfunction

  // Anything that is not a byte or halfword load behaves as a word load
  function automatic logic ld_is_word(input logic [2:0] t);
    return !((t == LD_B) || (t == LD_BU) || (t == LD_H) || (t == LD_HU));
  endfunction

endpackage

// File: rtl/load_align.sv
// Load data aligner: picks the addressed byte/halfword out of a 32-bit
// read word and sign- or zero-extends it. Purely combinational.
module load_align
  import cpu_defs::*;
(
  input  logic [2:0]  ld_type,
  input  logic [1:0]  sh,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed lane and extend it according to the load type
  always_comb begin
    byte_sel = rdata[{sh, 3'b000} +: 8];
    half_sel = rdata[{sh[1], 4'b0000} +: 16];
    case (ld_type)
      LD_B:    ld_data = {{24{byte_sel[7]}}, byte_sel};
      LD_BU:   ld_data = {24'h000000, byte_sel};
      LD_H:    ld_data = {{16{half_sel[15]}}, half_sel};
      LD_HU:   ld_data = {16'h0000, half_sel};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage of the 5-stage in-order pipeline. Latches the EX bus,
// holds the synchronous SRAM read data across WB stalls, aligns loads and
// drives the WB bus and the ID forwarding bus.
// Optional: define MEM_ALE_CHECK_EN to flag misaligned loads on mem_ale and
// suppress their register write.
module mem_stage
  import cpu_defs::*;
#(
  parameter int EX_BUS_W = EX_TO_MEM_W,
  parameter int WB_BUS_W = MEM_TO_WB_W,
  parameter int ID_BUS_W = MEM_TO_ID_W
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                EX_to_MEM_valid,
  input  logic [EX_BUS_W-1:0] EX_to_MEM_bus,
  output logic                MEM_allow_in,
  input  logic [31:0]         data_sram_rdata,
  input  logic                WB_allow_in,
  output logic                MEM_to_WB_valid,
  output logic [WB_BUS_W-1:0] MEM_to_WB_bus,
  output logic [ID_BUS_W-1:0] MEM_to_ID_bus,
  output logic                mem_ale
);

  logic                vld_p0;
  logic                fresh_p0;
  logic [31:0]         rdata_buf_p0;
  logic [EX_BUS_W-1:0] ex_bus_p0;

  logic        res_from_mem;
  logic [2:0]  ld_type;
  logic [31:0] alu_result;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] pc;
  logic [31:0] inst;
  logic [31:0] rdata_eff;
  logic [31:0] load_data;
  logic [31:0] final_result;
  logic        gr_we_eff;
  logic        capture;

  // MEM never stalls on its own, so it can take a new instruction whenever
  // it is empty or WB is draining the current one.
  assign MEM_allow_in    = ~vld_p0 | WB_allow_in;
  assign MEM_to_WB_valid = vld_p0;
  assign capture         = EX_to_MEM_valid & MEM_allow_in;

  // ---- EX -> MEM stage boundary ----
  // Control: occupancy flag and first-cycle marker for the SRAM return data
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_p0       <= 1'b0;
      fresh_p0     <= 1'b0;
      rdata_buf_p0 <= 32'h0;
    end else begin
      if (MEM_allow_in) vld_p0 <= EX_to_MEM_valid;
      fresh_p0 <= capture;
      if (fresh_p0) rdata_buf_p0 <= data_sram_rdata;
    end
  end

  // Payload: qualified by vld_p0, so it needs no reset
  always_ff @(posedge clk) begin
    if (capture) ex_bus_p0 <= EX_to_MEM_bus;
  end

  assign res_from_mem = ex_bus_p0[EXB_RES_FROM_MEM];
  assign ld_type      = ex_bus_p0[EXB_LD_TYPE_LSB +: 3];
  assign alu_result   = ex_bus_p0[EXB_ALU_LSB +: 32];
  assign gr_we        = ex_bus_p0[EXB_GR_WE];
  assign dest         = ex_bus_p0[EXB_DEST_LSB +: 5];
  assign pc           = ex_bus_p0[EXB_PC_LSB +: 32];
  assign inst         = ex_bus_p0[EXB_INST_LSB +: 32];

  // SRAM data is only live in the first occupancy cycle; afterwards the
  // buffered copy stands in for it.
  assign rdata_eff = fresh_p0 ? data_sram_rdata : rdata_buf_p0;

  load_align u_load_align (
    .ld_type (ld_type),
    .sh      (alu_result[1:0]),
    .rdata   (rdata_eff),
    .ld_data (load_data)
  );

  assign final_result = res_from_mem ? load_data : alu_result;

`ifdef MEM_ALE_CHECK_EN
  assign mem_ale = vld_p0 & res_from_mem &
                   ((ld_is_half(ld_type) & alu_result[0]) |
                    (ld_is_word(ld_type) & (alu_result[1:0] != 2'b00)));
`else
  assign mem_ale = 1'b0;
`endif

  // A misaligned load must not update the register file or be forwarded
  assign gr_we_eff = gr_we & ~mem_ale;

  assign MEM_to_WB_bus = {final_result, gr_we_eff, dest, pc, inst};
  assign MEM_to_ID_bus = {vld_p0 & gr_we_eff, vld_p0 & res_from_mem, dest, final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage with an expected-result scoreboard.
module tb_mem_stage;
  import cpu_defs::*;

  logic         clk = 1'b0;
  logic         resetn;
  logic         EX_to_MEM_valid;
  logic [105:0] EX_to_MEM_bus;
  logic         MEM_allow_in;
  logic [31:0]  data_sram_rdata;
  logic         WB_allow_in;
  logic         MEM_to_WB_valid;
  logic [101:0] MEM_to_WB_bus;
  logic [38:0]  MEM_to_ID_bus;
  logic         mem_ale;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .EX_to_MEM_valid (EX_to_MEM_valid),
    .EX_to_MEM_bus   (EX_to_MEM_bus),
    .MEM_allow_in    (MEM_allow_in),
    .data_sram_rdata (data_sram_rdata),
    .WB_allow_in     (WB_allow_in),
    .MEM_to_WB_valid (MEM_to_WB_valid),
    .MEM_to_WB_bus   (MEM_to_WB_bus),
    .MEM_to_ID_bus   (MEM_to_ID_bus),
    .mem_ale         (mem_ale)
  );

  typedef struct {
    logic [101:0] wb;
    logic [38:0]  id;
    logic         ale;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference load extraction, written with shifts and masks
  function automatic logic [31:0] ref_load(input logic [2:0] t, input logic [31:0] a,
                                           input logic [31:0] rd);
    logic [31:0] b;
    logic [31:0] h;
    b = (rd >> (8 * a[1:0])) & 32'hFF;
    h = (rd >> (16 * a[1])) & 32'hFFFF;
    if (t == LD_B)  return b[7]  ? (b | 32'hFFFF_FF00) : b;
    if (t == LD_BU) return b;
    if (t == LD_H)  return h[15] ? (h | 32'hFFFF_0000) : h;
    if (t == LD_HU) return h;
    return rd;
  endfunction

  function automatic logic ref_ale(input logic res, input logic [2:0] t, input logic [31:0] a);
`ifdef MEM_ALE_CHECK_EN
    if (!res) return 1'b0;
    if (t == LD_H || t == LD_HU) return a[0];
    if (t == LD_B || t == LD_BU) return 1'b0;
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [105:0] mk_ex(input logic res, input logic [2:0] t, input logic [31:0] a,
                                         input logic gw, input logic [4:0] d,
                                         input logic [31:0] pc, input logic [31:0] inst);
    return {res, t, a, gw, d, pc, inst};
  endfunction

  task automatic push_exp(input logic res, input logic [2:0] t, input logic [31:0] a,
                          input logic gw, input logic [4:0] d, input logic [31:0] pc,
                          input logic [31:0] inst, input logic [31:0] rd);
    exp_t e;
    logic [31:0] fr;
    logic        ale;
    logic        gwe;
    fr    = res ? ref_load(t, a, rd) : a;
    ale   = ref_ale(res, t, a);
    gwe   = gw & ~ale;
    e.wb  = {fr, gwe, d, pc, inst};
    e.id  = {gwe, res, d, fr};
    e.ale = ale;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Wait (bounded) for a handoff to WB and compare against the scoreboard head
  task automatic check_out(input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (!(MEM_to_WB_valid === 1'b1 && WB_allow_in === 1'b1) && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (n >= 8) begin
      checks++;
      failures++;
      $error("FAIL %s_timeout observed=no_handoff expected=handoff", tag);
    end else if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s_sb observed=unexpected_output expected=empty", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_wb"},  MEM_to_WB_bus, e.wb);
      chk({tag, "_id"},  MEM_to_ID_bus, e.id);
      chk({tag, "_ale"}, mem_ale,       e.ale);
    end
  endtask

  logic [2:0]  types [5];
  logic [31:0] rd;
  logic [31:0] addr;

  initial begin
    types[0] = LD_W; types[1] = LD_B; types[2] = LD_H; types[3] = LD_BU; types[4] = LD_HU;
    resetn          = 1'b0;
    EX_to_MEM_valid = 1'b0;
    EX_to_MEM_bus   = '0;
    data_sram_rdata = 32'h0;
    WB_allow_in     = 1'b1;

    // Reset state
    step(); step();
    mid();
    chk("rst_valid",    MEM_to_WB_valid,   1'b0);
    chk("rst_allow_in", MEM_allow_in,      1'b1);
    chk("rst_fwd_we",   MEM_to_ID_bus[38], 1'b0);
    chk("rst_ale",      mem_ale,           1'b0);
    step();
    resetn = 1'b1;

    // LD_B at 0x1003
    EX_to_MEM_valid = 1'b1;
    EX_to_MEM_bus   = mk_ex(1'b1, LD_B, 32'h1003, 1'b1, 5'd3, 32'h100, 32'h0000_00AA);
    push_exp(1'b1, LD_B, 32'h1003, 1'b1, 5'd3, 32'h100, 32'h0000_00AA, 32'h80FF_1234);
    step();
    EX_to_MEM_valid = 1'b0;
    data_sram_rdata = 32'h80FF_1234;
    mid();
    chk("lb_const", MEM_to_WB_bus[101:70], 32'hFFFF_FF80);
    chk("lb_grwe",  MEM_to_WB_bus[69],     1'b1);
    check_out("lb");
    step();
    data_sram_rdata = 32'h5555_AAAA;
    mid();
    chk("lb_drained", MEM_to_WB_valid, 1'b0);

    // LD_HU then LD_H back to back at 0x2002
    step();
    EX_to_MEM_valid = 1'b1;
    EX_to_MEM_bus   = mk_ex(1'b1, LD_HU, 32'h2002, 1'b1, 5'd6, 32'h104, 32'h0000_00BB);
    push_exp(1'b1, LD_HU, 32'h2002, 1'b1, 5'd6, 32'h104, 32'h0000_00BB, 32'hBEEF_0001);
    step();
    EX_to_MEM_bus   = mk_ex(1'b1, LD_H, 32'h2002, 1'b1, 5'd7, 32'h108, 32'h0000_00CC);
    push_exp(1'b1, LD_H, 32'h2002, 1'b1, 5'd7, 32'h108, 32'h0000_00CC, 32'hBEEF_0001);
    data_sram_rdata = 32'hBEEF_0001;
    mid();
    chk("lhu_const", MEM_to_WB_bus[101:70], 32'h0000_BEEF);
    check_out("lhu");
    step();
    EX_to_MEM_valid = 1'b0;
    mid();
    chk("lh_const", MEM_to_WB_bus[101:70], 32'hFFFF_BEEF);
    check_out("lh");
    step();
    data_sram_rdata = 32'h0;
    mid();
    chk("lh_drained", MEM_to_WB_valid, 1'b0);

    // Every load type at every byte offset with random read data
    for (int i = 0; i < 5; i++) begin
      for (int s = 0; s < 4; s++) begin
        step();
        rd   = $urandom;
        addr = 32'h4000 + 32'(s);
        EX_to_MEM_valid = 1'b1;
        EX_to_MEM_bus   = mk_ex(1'b1, types[i], addr, 1'b1, 5'(10 + s), 32'h200 + 32'(4 * i),
                                32'(i * 16 + s));
        push_exp(1'b1, types[i], addr, 1'b1, 5'(10 + s), 32'h200 + 32'(4 * i),
                 32'(i * 16 + s), rd);
        step();
        EX_to_MEM_valid = 1'b0;
        data_sram_rdata = rd;
        mid();
        check_out($sformatf("align_t%0d_s%0d", i, s));
        step();
        data_sram_rdata = ~rd;
      end
    end

    // LD_W held through a 3-cycle WB stall while SRAM data changes
    step();
    WB_allow_in     = 1'b0;
    EX_to_MEM_valid = 1'b1;
    EX_to_MEM_bus   = mk_ex(1'b1, LD_W, 32'h3000, 1'b1, 5'd8, 32'h300, 32'h0000_00DD);
    push_exp(1'b1, LD_W, 32'h3000, 1'b1, 5'd8, 32'h300, 32'h0000_00DD, 32'h1234_5678);
    step();
    EX_to_MEM_valid = 1'b0;
    data_sram_rdata = 32'h1234_5678;
    mid();
    chk("lw_fresh", MEM_to_WB_bus[101:70], 32'h1234_5678);
    chk("lw_fresh_allow", MEM_allow_in, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      data_sram_rdata = 32'hDEAD_DEAD;
      mid();
      chk($sformatf("lw_hold%0d", k), MEM_to_WB_bus[101:70], 32'h1234_5678);
      chk($sformatf("lw_allow%0d", k), MEM_allow_in, 1'b0);
    end
    WB_allow_in = 1'b1;
    #1;
    check_out("lw_stall");
    step();
    mid();
    chk("lw_single_handoff", MEM_to_WB_valid, 1'b0);

    // Two ADDs back to back, then a bubble
    step();
    EX_to_MEM_valid = 1'b1;
    EX_to_MEM_bus   = mk_ex(1'b0, LD_W, 32'd3, 1'b1, 5'd4, 32'h400, 32'h0000_0033);
    push_exp(1'b0, LD_W, 32'd3, 1'b1, 5'd4, 32'h400, 32'h0000_0033, 32'h0);
    step();
    EX_to_MEM_bus   = mk_ex(1'b0, LD_W, 32'd7, 1'b1, 5'd5, 32'h404, 32'h0000_0077);
    push_exp(1'b0, LD_W, 32'd7, 1'b1, 5'd5, 32'h404, 32'h0000_0077, 32'h0);
    mid();
    check_out("add1");
    step();
    EX_to_MEM_valid = 1'b0;
    mid();
    chk("add2_id_const", MEM_to_ID_bus, {1'b1, 1'b0, 5'd5, 32'd7});
    check_out("add2");
    step();
    mid();
    chk("bubble_fwd_we", MEM_to_ID_bus[38], 1'b0);

    // Misaligned word load
    step();
    EX_to_MEM_valid = 1'b1;
    EX_to_MEM_bus   = mk_ex(1'b1, LD_W, 32'h1001, 1'b1, 5'd9, 32'h500, 32'h0000_0099);
    push_exp(1'b1, LD_W, 32'h1001, 1'b1, 5'd9, 32'h500, 32'h0000_0099, 32'hCAFE_F00D);
    step();
    EX_to_MEM_valid = 1'b0;
    data_sram_rdata = 32'hCAFE_F00D;
    mid();
`ifdef MEM_ALE_CHECK_EN
    chk("ale_flag", mem_ale, 1'b1);
    chk("ale_grwe", MEM_to_WB_bus[69], 1'b0);
`else
    chk("ale_flag", mem_ale, 1'b0);
    chk("ale_grwe", MEM_to_WB_bus[69], 1'b1);
`endif
    check_out("ale");

    // Asynchronous reset in the middle of a stall
    step();
    WB_allow_in     = 1'b0;
    EX_to_MEM_valid = 1'b1;
    EX_to_MEM_bus   = mk_ex(1'b1, LD_W, 32'h6000, 1'b1, 5'd12, 32'h600, 32'h0000_0066);
    step();
    EX_to_MEM_valid = 1'b0;
    data_sram_rdata = 32'h0BAD_0BAD;
    step();
    mid();
    chk("stall_valid", MEM_to_WB_valid, 1'b1);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_rst_valid",  MEM_to_WB_valid,   1'b0);
    chk("async_rst_allow",  MEM_allow_in,      1'b1);
    chk("async_rst_fwd_we", MEM_to_ID_bus[38], 1'b0);
    step();
    resetn      = 1'b1;
    WB_allow_in = 1'b1;
    step();
    mid();
    chk("post_rst_valid", MEM_to_WB_valid, 1'b0);
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
